// File: rtl/rdma_pkg.sv
// Shared constants, beat type and PSN window comparison for the RDMA requester.
package rdma_pkg;

  localparam logic [7:0] OP_ACK        = 8'h11;
  localparam int         OP_HI         = 63;
  localparam int         OP_LO         = 56;
  localparam int         DATA_W        = 64;
  localparam int         PSN_W_DEFAULT = 24;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  // True when a is at or before b, i.e. (b - a) mod 2^w lies in the lower half of the PSN space.
  function automatic logic psn_le(input logic [63:0] a, input logic [63:0] b, input int unsigned w);
    logic [63:0] diff;
    diff = (b - a) & ((64'd1 << w) - 64'd1);
    return (diff >> (w - 1)) == 64'd0;
  endfunction

endpackage

// File: rtl/psn_fifo.sv
// In-order tracker of outstanding PSNs; head is readable combinationally for the completion check.
module psn_fifo
  import rdma_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = PSN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_psn,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_psn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rdma_modport.sv
// RC requester datapath: stamps a PSN on each host frame, tracks outstanding PSNs and
// pulses comp_valid once per message covered by a cumulative ACK.
module rdma_modport
  import rdma_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int PSN_W           = PSN_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_valid,
  input  logic [63:0] host_data,
  input  logic        host_last,
  input  logic        rx_valid,
  input  logic [63:0] rx_data,
  input  logic        rx_last,
  output logic        tx_valid,
  output logic [63:0] tx_data,
  output logic        tx_last,
  output logic        comp_valid
);

  beat_t            tx_q, tx_d;
  logic             host_first_q, host_first_d;
  logic             rx_first_q, rx_first_d;
  logic [PSN_W-1:0] next_psn_q, next_psn_d;
  logic [PSN_W-1:0] ack_psn_q, ack_psn_d;
  logic             ack_seen_q, ack_seen_d;
  logic             comp_valid_q, comp_valid_d;

  logic             host_sof;
  logic             rx_ack;
  logic             trk_pop;
  logic             trk_full;
  logic             trk_empty;
  logic [PSN_W-1:0] trk_head;
  logic             rx_unused;

  // Only the opcode and PSN fields of a receive beat carry meaning here.
  assign rx_unused = ^rx_data[OP_LO-1:PSN_W];

  always_comb begin
    host_sof     = host_valid && host_first_q;
    host_first_d = host_first_q;
    if (host_valid) begin
      host_first_d = host_last;
    end

    tx_d.valid = host_valid;
    tx_d.last  = host_last;
    tx_d.data  = host_data;
    if (host_sof) begin
      tx_d.data[PSN_W-1:0] = next_psn_q;
    end
    next_psn_d = next_psn_q + PSN_W'(host_sof);

    rx_first_d = rx_first_q;
    if (rx_valid) begin
      rx_first_d = rx_last;
    end
    rx_ack     = rx_valid && rx_first_q && (rx_data[OP_HI:OP_LO] == OP_ACK);
    ack_psn_d  = rx_ack ? rx_data[PSN_W-1:0] : ack_psn_q;
    ack_seen_d = ack_seen_q || rx_ack;

    // Completion uses the registered ACK, so a new ACK takes effect one edge after capture.
    trk_pop      = !trk_empty && ack_seen_q &&
                   psn_le(64'(trk_head), 64'(ack_psn_q), PSN_W);
    comp_valid_d = trk_pop;
  end

  psn_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (PSN_W)
  ) u_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (host_sof),
    .push_psn (next_psn_q),
    .pop      (trk_pop),
    .head     (trk_head),
    .full     (trk_full),
    .empty    (trk_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q         <= '0;
      host_first_q <= 1'b1;
      rx_first_q   <= 1'b1;
      next_psn_q   <= '0;
      ack_psn_q    <= '0;
      ack_seen_q   <= 1'b0;
      comp_valid_q <= 1'b0;
    end else begin
      tx_q         <= tx_d;
      host_first_q <= host_first_d;
      rx_first_q   <= rx_first_d;
      next_psn_q   <= next_psn_d;
      ack_psn_q    <= ack_psn_d;
      ack_seen_q   <= ack_seen_d;
      comp_valid_q <= comp_valid_d;
    end
  end

  logic full_unused;
  assign full_unused = trk_full;

  assign tx_valid   = tx_q.valid;
  assign tx_last    = tx_q.last;
  assign tx_data    = tx_q.data;
  assign comp_valid = comp_valid_q;

endmodule

// File: tb/tb_rdma_modport.sv
// Scoreboard bench for rdma_modport: expected tx beats and completion cycles are queued at drive time.
module tb_rdma_modport;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_valid = 1'b0;
  logic [63:0] host_data = '0;
  logic        host_last = 1'b0;
  logic        rx_valid = 1'b0;
  logic [63:0] rx_data = '0;
  logic        rx_last = 1'b0;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_last;
  logic        comp_valid;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic        last;
  } tx_exp_t;

  tx_exp_t     txq[$];
  int          compq[$];
  logic [23:0] m_trk[$];
  logic [23:0] m_psn = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  rdma_modport dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_last  (host_last),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_last    (rx_last),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .comp_valid (comp_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // a is at or before b when b lies less than half the 24-bit PSN space ahead of a.
  function automatic logic bench_le(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] d;
    d = b - a;
    return d < 24'h800000;
  endfunction

  always @(posedge clk) begin
    #1;
    if (tx_valid) begin
      if (txq.size() == 0) begin
        check("tx_extra", {63'd0, tx_valid}, 64'd0);
      end else begin
        tx_exp_t e;
        e = txq.pop_front();
        check("tx_cycle", 64'(cyc), 64'(e.cyc));
        check("tx_data", tx_data, e.data);
        check("tx_last", {63'd0, tx_last}, {63'd0, e.last});
      end
    end else if (txq.size() > 0 && txq[0].cyc <= cyc) begin
      check("tx_missing", {63'd0, tx_valid}, 64'd1);
      void'(txq.pop_front());
    end
    if (comp_valid) begin
      if (compq.size() == 0) begin
        check("comp_extra", {63'd0, comp_valid}, 64'd0);
      end else begin
        check("comp_cycle", 64'(cyc), 64'(compq.pop_front()));
      end
    end else if (compq.size() > 0 && compq[0] <= cyc) begin
      check("comp_missing", {63'd0, comp_valid}, 64'd1);
      void'(compq.pop_front());
    end
  end

  task automatic send_frame(input int n, input logic [63:0] d);
    tx_exp_t e;
    $display("host frame: beats=%0d psn=%06h tracked=%0d", n, m_psn, (m_trk.size() < 16));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      host_valid = 1'b1;
      host_data  = d;
      host_last  = (i == n - 1);
      e.cyc  = cyc + 1;
      e.data = d;
      e.last = (i == n - 1);
      if (i == 0) begin
        e.data[23:0] = m_psn;
        if (m_trk.size() < 16) m_trk.push_back(m_psn);
        m_psn = m_psn + 24'd1;
      end
      txq.push_back(e);
    end
    @(negedge clk);
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic send_rx(input int n, input logic [63:0] d0, input logic [63:0] d1);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = (i == 0) ? d0 : d1;
      rx_last  = (i == n - 1);
      if (i == 0 && d0[63:56] == 8'h11) begin
        while (m_trk.size() > 0 && bench_le(m_trk[0], d0[23:0])) begin
          void'(m_trk.pop_front());
          compq.push_back(cyc + 2 + k);
          k++;
        end
      end
    end
    $display("rx frame: beats=%0d opcode=%02h psn=%06h expected_completions=%0d",
             n, d0[63:56], d0[23:0], k);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((txq.size() > 0 || compq.size() > 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("drain", 64'(txq.size() + compq.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    host_valid = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_psn = '0;
    m_trk.delete();
    $display("reset pulse");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tx_exp_t e;
    // Reset held with toggling inputs: all outputs must stay 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      host_valid = 1'b1;
      host_last  = i[0];
      host_data  = {$urandom, $urandom};
      rx_valid   = 1'b1;
      rx_last    = 1'b1;
      rx_data    = {8'h11, 32'd0, 24'd0};
      @(posedge clk);
      #1;
      check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
      check("rst_tx_last", {63'd0, tx_last}, 64'd0);
      check("rst_tx_data", tx_data, 64'd0);
      check("rst_comp", {63'd0, comp_valid}, 64'd0);
    end
    @(negedge clk);
    host_valid = 1'b0;
    rx_valid   = 1'b0;
    rx_last    = 1'b0;
    rst_n      = 1'b1;

    // Stamping and cumulative ACK.
    send_frame(3, 64'hAA00_0000_00FF_FFFF);
    send_frame(1, 64'h1234_5678_9ABC_DEF0);
    send_frame(2, 64'h0F0F_0F0F_F0F0_F0F0);
    send_frame(1, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    send_rx(1, {8'h11, 32'd0, 24'd2}, 64'd0);
    drain();
    send_rx(1, {8'h11, 32'd0, 24'd3}, 64'd0);
    drain();

    // Ignored receive traffic: non-first beat ACK, other opcode, stale ACK.
    send_frame(1, 64'h5555_0000_0000_0000);
    send_frame(2, 64'h6666_0000_0000_0001);
    send_frame(1, 64'h7777_0000_0000_0002);
    send_rx(2, {8'h22, 32'd0, 24'd0}, {8'h11, 32'd0, 24'd5});
    send_rx(1, {8'h12, 32'd0, 24'd5}, 64'd0);
    send_rx(1, {8'h11, 32'd0, 24'd1}, 64'd0);
    drain();
    send_rx(1, {8'h11, 32'hDEAD_BEEF, 24'd6}, 64'd0);
    drain();

    // Tracker overflow: PSN 16 is transmitted but never completed.
    do_reset();
    for (int i = 0; i < 17; i++) send_frame(1, {32'h0BAD_F00D, i[31:0]});
    drain();
    send_rx(1, {8'h11, 32'd0, 24'd16}, 64'd0);
    drain();
    send_frame(1, 64'h1111_2222_3333_4444);
    send_rx(1, {8'h11, 32'd0, 24'd17}, 64'd0);
    drain();

    // PSN wrap via backdoor, then ACK 1 covers FFFFFF, 000000, 000001.
    do_reset();
    force dut.next_psn_q = 24'hFFFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.next_psn_q;
    m_psn = 24'hFFFFFF;
    send_frame(1, 64'hA1A1_A1A1_A1A1_A1A1);
    send_frame(2, 64'hB2B2_B2B2_B2B2_B2B2);
    send_frame(1, 64'hC3C3_C3C3_C3C3_C3C3);
    drain();
    send_rx(1, {8'h11, 32'd0, 24'd1}, 64'd0);
    drain();

    // Mid-frame reset: the first beat after reset starts a new frame with PSN 0.
    @(negedge clk);
    host_valid = 1'b1;
    host_last  = 1'b0;
    host_data  = 64'hD00D_0000_0000_0000;
    e.cyc  = cyc + 1;
    e.data = {40'hD00D_0000_00, m_psn};
    e.last = 1'b0;
    txq.push_back(e);
    $display("host beat: mid-frame start psn=%06h", m_psn);
    @(negedge clk);
    rst_n     = 1'b0;
    host_data = 64'hE00E_0000_0000_0000;
    @(negedge clk);
    rst_n      = 1'b1;
    host_valid = 1'b0;
    m_psn = '0;
    m_trk.delete();
    send_frame(1, 64'hF00F_0000_00AB_CDEF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
